// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the mem_seq burst sequencer.
// The FILL state only exists when MEM_SEQ_FILL_EN is defined.
package mem_seq_pkg;

    localparam int unsigned MEM_SEQ_L    = 10;
    localparam int unsigned MEM_SEQ_WRAP = MEM_SEQ_L - 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
`ifdef MEM_SEQ_FILL_EN
        FILL     = 3'd2,
`endif
        RD_ISSUE = 3'd3,
        RD_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/mem_seq_addr_gen.sv
// Burst address/length tracker for mem_seq: next address with wrap at L-1
// and a remaining-beats counter whose zero value flags the last beat.
module mem_seq_addr_gen
    import mem_seq_pkg::*;
#(
    parameter int unsigned L  = MEM_SEQ_L,
    parameter int unsigned AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [AW-1:0] load_cnt,
    input  logic          step_addr,
    input  logic          step_cnt,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] WRAP_ADDR = AW'(L - 1);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] cnt_q;

    // Load on request acceptance; otherwise step address (wrapping) and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= {AW{1'b0}};
            cnt_q  <= {AW{1'b0}};
        end else if (load) begin
            addr_q <= load_addr;
            cnt_q  <= load_cnt;
        end else begin
            if (step_addr) begin
                if (addr_q == WRAP_ADDR) begin
                    addr_q <= {AW{1'b0}};
                end else begin
                    addr_q <= addr_q + AW'(1);
                end
            end
            if (step_cnt && (cnt_q != {AW{1'b0}})) begin
                cnt_q <= cnt_q - AW'(1);
            end
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == {AW{1'b0}});

endmodule

// File: rtl/mem_seq.sv
// Burst sequencer between valid/ready streams and a single-port synchronous
// memory. Optional zero-fill bursts are enabled by defining MEM_SEQ_FILL_EN.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned L  = MEM_SEQ_L,
    parameter int unsigned AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic          req_fill,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len_m1,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [W-1:0]  wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [W-1:0]  rd_data,
    output logic          done,
    output logic          done_err,
    output logic          mem_wrt_read,
    output logic          mem_enable,
    output logic [AW-1:0] mem_add,
    output logic [W-1:0]  mem_write,
    input  logic [W-1:0]  mem_out
);

    localparam logic [AW:0] DEPTH = (AW+1)'(L);

    state_t        state_q;
    state_t        state_d;
    logic          err_q;
    logic          err_d;
    logic          load;
    logic          step_addr;
    logic          step_cnt;
    logic [AW-1:0] addr;
    logic          last;
    logic          addr_bad;

`ifndef MEM_SEQ_FILL_EN
    logic unused_req_fill;
    assign unused_req_fill = req_fill;
`endif

    assign addr_bad = ({1'b0, req_addr} >= DEPTH);

    mem_seq_addr_gen #(
        .L  (L),
        .AW (AW)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_addr (req_addr),
        .load_cnt  (req_len_m1),
        .step_addr (step_addr),
        .step_cnt  (step_cnt),
        .addr      (addr),
        .last      (last)
    );

    // State and latched reject flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next state, stream handshakes and memory command; idle port parks on addr_q.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        load         = 1'b0;
        step_addr    = 1'b0;
        step_cnt     = 1'b0;
        req_ready    = 1'b0;
        wr_ready     = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = {W{1'b0}};
        done         = 1'b0;
        done_err     = 1'b0;
        mem_enable   = 1'b0;
        mem_wrt_read = 1'b0;
        mem_add      = addr;
        mem_write    = {W{1'b0}};

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load  = 1'b1;
                    err_d = 1'b0;
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = DONE;
`ifdef MEM_SEQ_FILL_EN
                    end else if (req_fill) begin
                        state_d = FILL;
`endif
                    end else if (req_wr) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_enable   = 1'b1;
                    mem_wrt_read = 1'b1;
                    mem_write    = wr_data;
                    step_addr    = 1'b1;
                    step_cnt     = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        state_d = WR;
                    end
                end else begin
                    state_d = WR;
                end
            end

`ifdef MEM_SEQ_FILL_EN
            FILL: begin
                mem_enable   = 1'b1;
                mem_wrt_read = 1'b1;
                step_addr    = 1'b1;
                step_cnt     = 1'b1;
                if (last) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
`endif

            RD_ISSUE: begin
                mem_enable = 1'b1;
                step_addr  = 1'b1;
                state_d    = RD_HOLD;
            end

            // Next read issues on the same edge the client samples the current word.
            RD_HOLD: begin
                rd_valid = 1'b1;
                rd_data  = mem_out;
                if (rd_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        mem_enable = 1'b1;
                        step_addr  = 1'b1;
                        step_cnt   = 1'b1;
                        state_d    = RD_HOLD;
                    end
                end else begin
                    state_d = RD_HOLD;
                end
            end

            DONE: begin
                done     = 1'b1;
                done_err = err_q;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_seq.sv
// Randomized self-checking bench for mem_seq with a behavioural memory and a
// burst-level reference model; exercises FILL when MEM_SEQ_FILL_EN is defined.
module tb_mem_seq;
    import mem_seq_pkg::*;

    localparam int W  = 8;
    localparam int L  = MEM_SEQ_L;
    localparam int AW = $clog2(L);
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_wr, req_fill;
    logic [AW-1:0] req_addr, req_len_m1;
    logic          wr_valid, wr_ready;
    logic [W-1:0]  wr_data;
    logic          rd_valid, rd_ready;
    logic [W-1:0]  rd_data;
    logic          done, done_err;
    logic          mem_wrt_read, mem_enable;
    logic [AW-1:0] mem_add;
    logic [W-1:0]  mem_write, mem_out;

    logic [W-1:0]  tb_mem   [0:(1<<AW)-1];
    logic [W-1:0]  pre_data [0:(1<<AW)-1];
    logic [W-1:0]  ref_mem  [0:L-1];
    logic [W-1:0]  beat_data[0:15];
    logic          preload;

    int n_checks = 0;
    int n_errors = 0;

    mem_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_fill(req_fill),
        .req_addr(req_addr), .req_len_m1(req_len_m1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .done_err(done_err),
        .mem_wrt_read(mem_wrt_read), .mem_enable(mem_enable), .mem_add(mem_add),
        .mem_write(mem_write), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory with registered read data.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < (1<<AW); k++) tb_mem[k] <= pre_data[k];
        end else if (mem_enable) begin
            if (mem_wrt_read) tb_mem[mem_add] <= mem_write;
            else              mem_out <= tb_mem[mem_add];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic fill_noise();
`ifdef MEM_SEQ_FILL_EN
        return 1'b0;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    task automatic compare_mem(input string tag);
        for (int k = 0; k < L; k++) check(tag, 32'(tb_mem[k]), 32'(ref_mem[k]));
    endtask

    task automatic do_preload();
        @(negedge clk);
        for (int k = 0; k < (1<<AW); k++) pre_data[k] = W'($urandom);
        for (int k = 0; k < L; k++) ref_mem[k] = pre_data[k];
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] n, input bit stall);
        int i = 0;
        int cycles = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_fill = fill_noise();
        req_addr = a; req_len_m1 = n;
        #1 check("wr_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        while (i <= int'(n) && cycles < TO) begin
            wr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = wr_valid ? beat_data[i] : W'($urandom);
            #1;
            check("wr_ready", 32'(wr_ready), 32'd1);
            check("wr_mem_en", 32'(mem_enable), 32'(wr_valid));
            if (wr_valid) begin
                check("wr_mem_dir", 32'(mem_wrt_read), 32'd1);
                check("wr_mem_add", 32'(mem_add), 32'((int'(a) + i) % L));
                check("wr_mem_data", 32'(mem_write), 32'(beat_data[i]));
                i++;
            end
            cycles++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (cycles >= TO) check("wr_timeout", 32'd0, 32'd1);
        #1;
        check("wr_done", 32'(done), 32'd1);
        check("wr_done_err", 32'(done_err), 32'd0);
        for (int j = 0; j <= int'(n); j++) ref_mem[(int'(a) + j) % L] = beat_data[j];
        compare_mem("wr_mem_contents");
    endtask

    // mode 0: rd_ready toggles 1,0,1,0..; 1: random; otherwise always ready.
    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] n, input int mode);
        int beats = 0;
        int cycles = 0;
        bit stalled = 1'b0;
        logic [W-1:0] held = '0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_fill = fill_noise();
        req_addr = a; req_len_m1 = n;
        #1 check("rd_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; rd_ready = 1'b0;
        #1;
        check("rd_issue_valid", 32'(rd_valid), 32'd0);
        check("rd_issue_en", 32'(mem_enable), 32'd1);
        check("rd_issue_dir", 32'(mem_wrt_read), 32'd0);
        check("rd_issue_add", 32'(mem_add), 32'(a));
        @(negedge clk);
        while (beats <= int'(n) && cycles < TO) begin
            case (mode)
                0:       rd_ready = (cycles % 2 == 0);
                1:       rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b1;
            endcase
            #1;
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", 32'(rd_data), 32'(ref_mem[(int'(a) + beats) % L]));
            if (stalled) check("rd_hold", 32'(rd_data), 32'(held));
            held = rd_data;
            stalled = !rd_ready;
            if (rd_ready) begin
                if (beats < int'(n)) begin
                    check("rd_next_en", 32'(mem_enable), 32'd1);
                    check("rd_next_add", 32'(mem_add), 32'((int'(a) + beats + 1) % L));
                end else begin
                    check("rd_last_en", 32'(mem_enable), 32'd0);
                end
                beats++;
            end else begin
                check("rd_stall_en", 32'(mem_enable), 32'd0);
            end
            cycles++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        if (cycles >= TO) check("rd_timeout", 32'd0, 32'd1);
        #1;
        check("rd_done", 32'(done), 32'd1);
        check("rd_done_err", 32'(done_err), 32'd0);
        check("rd_done_valid", 32'(rd_valid), 32'd0);
    endtask

    task automatic do_bad(input logic [AW-1:0] a, input logic wr);
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_fill = fill_noise();
        req_addr = a; req_len_m1 = AW'($urandom);
        #1;
        check("bad_req_ready", 32'(req_ready), 32'd1);
        check("bad_idle_en", 32'(mem_enable), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; wr_valid = 1'b1; rd_ready = 1'b1;
        #1;
        check("bad_done", 32'(done), 32'd1);
        check("bad_done_err", 32'(done_err), 32'd1);
        check("bad_mem_en", 32'(mem_enable), 32'd0);
        check("bad_wr_ready", 32'(wr_ready), 32'd0);
        check("bad_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        check("bad_done_clear", 32'(done), 32'd0);
        check("bad_back_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] n;
        int kind;

        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_fill = 1'b0;
        req_addr = '0; req_len_m1 = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        for (int k = 0; k < (1<<AW); k++) pre_data[k] = W'($urandom);
        for (int k = 0; k < L; k++) ref_mem[k] = pre_data[k];
        repeat (3) @(negedge clk);
        reset = 1'b0; preload = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_err", 32'(done_err), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_mem_en", 32'(mem_enable), 32'd0);
        check("rst_mem_dir", 32'(mem_wrt_read), 32'd0);
        check("rst_mem_add", 32'(mem_add), 32'd0);

        // Basic write, read back with toggling back-pressure, wrap-around.
        for (int j = 0; j < 4; j++) beat_data[j] = W'(8'hA1 + j);
        do_write(AW'(2), AW'(3), 1'b0);
        do_read(AW'(2), AW'(3), 0);
        for (int j = 0; j < 4; j++) beat_data[j] = W'(8'h11 + j);
        do_write(AW'(8), AW'(3), 1'b0);
        do_read(AW'(8), AW'(3), 2);

        do_bad(AW'(12), 1'b1);
        do_bad(AW'(L), 1'b0);

        // Reset in the middle of a 6-beat read after two beats.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_fill = 1'b0;
        req_addr = AW'(1); req_len_m1 = AW'(5);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rd_ready = 1'b1;
        #1 check("rst_mid_beat0", 32'(rd_data), 32'(ref_mem[1]));
        @(negedge clk);
        #1 check("rst_mid_beat1", 32'(rd_data), 32'(ref_mem[2]));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; rd_ready = 1'b0;
        #1;
        check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        #1 check("rst_mid_no_done", 32'(done), 32'd0);

        // Randomized mix of bursts, including bursts longer than memory depth.
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 9);
            a = AW'($urandom_range(0, L - 1));
            n = AW'($urandom_range(0, (1<<AW) - 1));
            if (kind < 4) begin
                for (int j = 0; j < 16; j++) beat_data[j] = W'($urandom);
                do_write(a, n, 1'b1);
            end else if (kind < 8) begin
                do_read(a, n, 1);
            end else begin
                do_bad(AW'($urandom_range(L, (1<<AW) - 1)), 1'($urandom_range(0, 1)));
            end
        end

`ifdef MEM_SEQ_FILL_EN
        begin
            int cnt = 0;
            int cycles = 0;
            do_preload();
            @(negedge clk);
            req_valid = 1'b1; req_fill = 1'b1; req_wr = 1'($urandom_range(0, 1));
            req_addr = AW'(0); req_len_m1 = AW'(L - 1);
            @(negedge clk);
            req_valid = 1'b0; req_fill = 1'b0;
            #1;
            while (done == 1'b0 && cycles < TO) begin
                check("fill_en", 32'(mem_enable), 32'd1);
                check("fill_dir", 32'(mem_wrt_read), 32'd1);
                check("fill_data", 32'(mem_write), 32'd0);
                check("fill_add", 32'(mem_add), 32'(cnt % L));
                check("fill_wr_ready", 32'(wr_ready), 32'd0);
                cnt++;
                cycles++;
                @(negedge clk);
                #1;
            end
            check("fill_cycles", 32'(cnt), 32'(L));
            check("fill_done_err", 32'(done_err), 32'd0);
            for (int k = 0; k < L; k++) ref_mem[k] = '0;
            compare_mem("fill_mem_contents");
            do_read(AW'(0), AW'(L - 1), 2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
